seq_mantissa_multiplier: RTL and testbench



---
 rtl/mant_mul_pkg.sv | 23 ++
 rtl/seq_mantissa_multiplier_if.sv | 28 ++
 rtl/mant_round_norm.sv | 43 ++++
 rtl/seq_mantissa_multiplier.sv | 120 ++++++++++++
 tb/tb_seq_mantissa_multiplier.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/mant_mul_pkg.sv
// Shared types, round-mode encodings and sizing helpers for the sequential
// significand multiplier.
package mant_mul_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    NORM = 2'd2,
    DONE = 2'd3
  } state_e;

  localparam logic RND_TRUNC = 1'b0;
  localparam logic RND_RNE   = 1'b1;

  function automatic int calc_iter(input int mant_width, input int bits_per_cycle);
    return (mant_width + 1) / bits_per_cycle;
  endfunction

  function automatic int calc_cnt_width(input int mant_width, input int bits_per_cycle);
    return $clog2(calc_iter(mant_width, bits_per_cycle) + 1);
  endfunction

endpackage

// File: rtl/seq_mantissa_multiplier_if.sv
// Operand and result valid/ready handshakes of the significand multiplier.
// The master side feeds operands and drains results; the multiplier is the slave.
interface seq_mantissa_multiplier_if #(
  parameter int MANT_WIDTH = 23
);

  logic                  in_valid;
  logic                  in_ready;
  logic [MANT_WIDTH-1:0] in0;
  logic [MANT_WIDTH-1:0] in1;
  logic                  round_mode;
  logic                  out_valid;
  logic                  out_ready;
  logic [MANT_WIDTH-1:0] out;
  logic                  out_carry;
  logic                  out_inexact;

  modport master (
    output in_valid, in0, in1, round_mode, out_ready,
    input  in_ready, out_valid, out, out_carry, out_inexact
  );

  modport slave (
    input  in_valid, in0, in1, round_mode, out_ready,
    output in_ready, out_valid, out, out_carry, out_inexact
  );

endinterface

// File: rtl/mant_round_norm.sv
// Normalises an exact 2N+2-bit significand product to [1,2) and rounds the
// fraction (truncate or RNE), reporting exponent carry and inexactness.
module mant_round_norm
  import mant_mul_pkg::*;
#(
  parameter int MANT_WIDTH = 23
) (
  input  logic [2*MANT_WIDTH+1:0] prod_i,
  input  logic                    mode_i,
  output logic [MANT_WIDTH-1:0]   frac_o,
  output logic                    carry_o,
  output logic                    inexact_o
);

  localparam int N = MANT_WIDTH;

  logic         hi_s;
  logic         guard_s;
  logic         sticky_s;
  logic         inc_s;
  logic [N-1:0] frac_pre_s;
  logic [N:0]   frac_rnd_s;

  always_comb begin
    hi_s = prod_i[2*N+1];
    if (hi_s) begin
      frac_pre_s = prod_i[2*N:N+1];
      guard_s    = prod_i[N];
      sticky_s   = |prod_i[N-1:0];
    end else begin
      frac_pre_s = prod_i[2*N-1:N];
      guard_s    = prod_i[N-1];
      sticky_s   = |prod_i[N-2:0];
    end
    inc_s      = (mode_i == RND_RNE) && guard_s && (sticky_s || frac_pre_s[0]);
    frac_rnd_s = {1'b0, frac_pre_s} + {{N{1'b0}}, inc_s};
    // A rounding overflow wraps the fraction to zero and moves into the carry.
    frac_o     = frac_rnd_s[N-1:0];
    carry_o    = hi_s | frac_rnd_s[N];
    inexact_o  = guard_s | sticky_s;
  end

endmodule

// File: rtl/seq_mantissa_multiplier.sv
// Iterative shift-add significand multiplier: BITS_PER_CYCLE multiplier bits per
// clock, then one cycle of normalise/round into registered outputs.
module seq_mantissa_multiplier
  import mant_mul_pkg::*;
#(
  parameter int MANT_WIDTH     = 23,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  seq_mantissa_multiplier_if.slave  bus
);

  localparam int N     = MANT_WIDTH;
  localparam int K     = BITS_PER_CYCLE;
  localparam int SIG_W = N + 1;
  localparam int ACC_W = 2 * N + 2;
  localparam int PP_W  = SIG_W + K;
  localparam int ITER  = calc_iter(N, K);
  localparam int CNT_W = calc_cnt_width(N, K);

  localparam logic [CNT_W-1:0] ITER_C = CNT_W'(ITER);
  localparam logic [CNT_W-1:0] ONE_C  = CNT_W'(1);

  generate
    if ((K < 1) || (K > N) || ((SIG_W % K) != 0)) begin : g_bad_k
      $error("BITS_PER_CYCLE must divide MANT_WIDTH+1");
    end
  endgenerate

  state_e             state_q;
  logic [SIG_W-1:0]   a_q;
  logic [SIG_W-1:0]   b_q;
  logic               mode_q;
  logic [ACC_W-1:0]   acc_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [N-1:0]       out_q;
  logic               carry_q;
  logic               inexact_q;

  logic [PP_W-1:0]    sum_d;
  logic [ACC_W-1:0]   acc_d;
  logic [SIG_W-1:0]   b_d;
  logic [N-1:0]       frac_s;
  logic               carry_s;
  logic               inexact_s;

  // The upper accumulator half stays below A after every shift, so the sum fits PP_W bits.
  always_comb begin
    sum_d = PP_W'(acc_q[ACC_W-1:N+1]) + (PP_W'(a_q) * PP_W'(b_q[K-1:0]));
    acc_d = {sum_d, acc_q[N:K]};
    b_d   = b_q >> K;
  end

  mant_round_norm #(
    .MANT_WIDTH (N)
  ) u_round_norm (
    .prod_i    (acc_q),
    .mode_i    (mode_q),
    .frac_o    (frac_s),
    .carry_o   (carry_s),
    .inexact_o (inexact_s)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      mode_q    <= RND_TRUNC;
      acc_q     <= '0;
      cnt_q     <= '0;
      out_q     <= '0;
      carry_q   <= 1'b0;
      inexact_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            a_q     <= {1'b1, bus.in0};
            b_q     <= {1'b1, bus.in1};
            mode_q  <= bus.round_mode;
            acc_q   <= '0;
            cnt_q   <= ITER_C;
            state_q <= BUSY;
          end
        end
        BUSY: begin
          acc_q <= acc_d;
          b_q   <= b_d;
          cnt_q <= cnt_q - ONE_C;
          if (cnt_q == ONE_C) begin
            state_q <= NORM;
          end
        end
        NORM: begin
          out_q     <= frac_s;
          carry_q   <= carry_s;
          inexact_q <= inexact_s;
          state_q   <= DONE;
        end
        DONE: begin
          if (bus.out_ready) begin
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready    = (state_q == IDLE);
  assign bus.out_valid   = (state_q == DONE);
  assign bus.out         = out_q;
  assign bus.out_carry   = carry_q;
  assign bus.out_inexact = inexact_q;

endmodule

// File: tb/tb_seq_mantissa_multiplier.sv
// Directed table for the k=1 multiplier plus stall/reset sequences, and a
// randomised k=4 instance checked against an arithmetic reference model.
module tb_seq_mantissa_multiplier;
  import mant_mul_pkg::*;

  localparam int N = 23;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  seq_mantissa_multiplier_if #(.MANT_WIDTH(N)) bus1 ();
  seq_mantissa_multiplier_if #(.MANT_WIDTH(N)) bus4 ();

  seq_mantissa_multiplier #(.MANT_WIDTH(N), .BITS_PER_CYCLE(1)) u_dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  seq_mantissa_multiplier #(.MANT_WIDTH(N), .BITS_PER_CYCLE(4)) u_dut4 (
    .clk (clk),
    .rst (rst),
    .bus (bus4)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         m;
    logic [N-1:0] e_out;
    logic         e_c;
    logic         e_x;
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // Exact product, then divide by the normalising power of two and round on the remainder.
  task automatic ref_model(input logic [N-1:0] a, input logic [N-1:0] b, input logic m,
                           output logic [N-1:0] o, output logic c, output logic x);
    logic [47:0] p, q, r, half;
    int sh;
    p    = 48'({1'b1, a}) * 48'({1'b1, b});
    sh   = p[47] ? 24 : 23;
    q    = p >> sh;
    r    = p - (q << sh);
    half = 48'd1 << (sh - 1);
    x    = (r != 48'd0);
    if (m && ((r > half) || ((r == half) && q[0]))) q = q + 48'd1;
    if (sh == 24) begin
      checks++;
      if (q == 48'h100_0000) begin
        errors++;
        $display("FAIL model_carry_round_ovf actual=0x%0h expected=below 0x1000000", q);
      end
    end
    c = (sh == 24) || (q == 48'h100_0000);
    o = q[N-1:0];
  endtask

  task automatic run_op1(input logic [N-1:0] a, input logic [N-1:0] b, input logic m,
                         input int stall, input string tag,
                         output logic [N-1:0] o, output logic c, output logic x,
                         output int lat);
    int n;
    logic ok;
    @(negedge clk);
    bus1.in0 = a; bus1.in1 = b; bus1.round_mode = m; bus1.in_valid = 1'b1;
    n = 0;
    while (!bus1.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1 bus1.in_valid = 1'b0;
    lat = 0;
    ok  = 1'b0;
    while (!ok && lat < 100) begin
      @(posedge clk);
      lat++;
      #1;
      if (bus1.out_valid) ok = 1'b1;
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout actual=no out_valid expected=out_valid", tag);
    end
    o = bus1.out; c = bus1.out_carry; x = bus1.out_inexact;
    for (int s = 0; s < stall; s++) begin
      @(posedge clk);
      #1;
      check($sformatf("%s_stall_out", tag), 32'(bus1.out), 32'(o));
      check($sformatf("%s_stall_c", tag), 32'(bus1.out_carry), 32'(c));
      check($sformatf("%s_stall_x", tag), 32'(bus1.out_inexact), 32'(x));
      check($sformatf("%s_stall_valid", tag), 32'(bus1.out_valid), 32'd1);
      check($sformatf("%s_stall_inrdy", tag), 32'(bus1.in_ready), 32'd0);
    end
    @(negedge clk);
    bus1.out_ready = 1'b1;
    @(posedge clk);
    #1 bus1.out_ready = 1'b0;
    check($sformatf("%s_back_idle", tag), 32'(bus1.in_ready), 32'd1);
  endtask

  initial begin
    logic [N-1:0] o, e_o, a, b;
    logic c, x, e_c, e_x, m, ok, seen;
    int lat, n;

    vecs[0] = '{23'h000000, 23'h000000, RND_RNE,   23'h000000, 1'b0, 1'b0};
    vecs[1] = '{23'h400000, 23'h400000, RND_RNE,   23'h100000, 1'b1, 1'b0};
    vecs[2] = '{23'h7FFFFF, 23'h7FFFFF, RND_TRUNC, 23'h7FFFFE, 1'b1, 1'b1};
    vecs[3] = '{23'h7FFFFF, 23'h7FFFFF, RND_RNE,   23'h7FFFFE, 1'b1, 1'b1};
    vecs[4] = '{23'h000001, 23'h400000, RND_TRUNC, 23'h400001, 1'b0, 1'b1};
    vecs[5] = '{23'h000001, 23'h400000, RND_RNE,   23'h400002, 1'b0, 1'b1};
    vecs[6] = '{23'h7FFFFE, 23'h000001, RND_RNE,   23'h000000, 1'b1, 1'b1};
    vecs[7] = '{23'h7FFFFE, 23'h000001, RND_TRUNC, 23'h7FFFFF, 1'b0, 1'b1};
    vecs[8] = '{23'h400000, 23'h000000, RND_TRUNC, 23'h400000, 1'b0, 1'b0};

    bus1.in_valid = 1'b0; bus1.out_ready = 1'b0; bus1.in0 = '0; bus1.in1 = '0; bus1.round_mode = 1'b0;
    bus4.in_valid = 1'b0; bus4.out_ready = 1'b0; bus4.in0 = '0; bus4.in1 = '0; bus4.round_mode = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rst_in_ready", 32'(bus1.in_ready), 32'd1);
    check("rst_out_valid", 32'(bus1.out_valid), 32'd0);
    check("rst_out", 32'(bus1.out), 32'd0);
    check("rst_carry", 32'(bus1.out_carry), 32'd0);
    check("rst_inexact", 32'(bus1.out_inexact), 32'd0);
    check("rst4_in_ready", 32'(bus4.in_ready), 32'd1);

    for (int i = 0; i < 9; i++) begin
      run_op1(vecs[i].a, vecs[i].b, vecs[i].m, 0, $sformatf("v%0d", i), o, c, x, lat);
      check($sformatf("v%0d_out", i), 32'(o), 32'(vecs[i].e_out));
      check($sformatf("v%0d_carry", i), 32'(c), 32'(vecs[i].e_c));
      check($sformatf("v%0d_inexact", i), 32'(x), 32'(vecs[i].e_x));
      check($sformatf("v%0d_latency", i), 32'(lat), 32'd25);
    end

    // Ten cycles of backpressure on a result.
    run_op1(23'h7FFFFF, 23'h7FFFFF, RND_RNE, 10, "stall", o, c, x, lat);
    check("stall_out", 32'(o), 32'h7FFFFE);

    // Reset part-way through BUSY must abort with no result.
    @(negedge clk);
    bus1.in0 = 23'h123456; bus1.in1 = 23'h654321; bus1.round_mode = RND_RNE; bus1.in_valid = 1'b1;
    @(posedge clk);
    #1 bus1.in_valid = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_in_ready", 32'(bus1.in_ready), 32'd1);
    check("midrst_out_valid", 32'(bus1.out_valid), 32'd0);
    check("midrst_out", 32'(bus1.out), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (bus1.out_valid) seen = 1'b1;
    end
    check("midrst_no_result", 32'(seen), 32'd0);
    run_op1(23'h000001, 23'h400000, RND_RNE, 0, "post_rst", o, c, x, lat);
    check("post_rst_out", 32'(o), 32'h400002);
    check("post_rst_carry", 32'(c), 32'd0);
    check("post_rst_inexact", 32'(x), 32'd1);
    check("post_rst_latency", 32'(lat), 32'd25);

    // k=4 instance: random operands and handshake gaps against the model.
    for (int t = 0; t < 1000; t++) begin
      a = N'($urandom);
      b = N'($urandom);
      m = 1'($urandom_range(0, 1));
      ref_model(a, b, m, e_o, e_c, e_x);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      @(negedge clk);
      bus4.in0 = a; bus4.in1 = b; bus4.round_mode = m; bus4.in_valid = 1'b1;
      n = 0;
      while (!bus4.in_ready && n < 50) begin
        @(negedge clk);
        n++;
      end
      @(posedge clk);
      #1 bus4.in_valid = 1'b0;
      lat = 0;
      ok  = 1'b0;
      while (!ok && lat < 100) begin
        @(posedge clk);
        lat++;
        #1;
        if (bus4.out_valid) ok = 1'b1;
      end
      check($sformatf("r%0d_latency", t), 32'(lat), 32'd7);
      check($sformatf("r%0d_out", t), 32'(bus4.out), 32'(e_o));
      check($sformatf("r%0d_carry", t), 32'(bus4.out_carry), 32'(e_c));
      check($sformatf("r%0d_inexact", t), 32'(bus4.out_inexact), 32'(e_x));
      repeat ($urandom_range(0, 3)) @(negedge clk);
      @(negedge clk);
      bus4.out_ready = 1'b1;
      @(posedge clk);
      #1 bus4.out_ready = 1'b0;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
